// File: rtl/cdc_handshake_arbiter_if.sv
// Signal bundle between the local requesters/CDC link and the handshake arbiter.
// The master modport is the arbiter; the slave modport is the requester and far-side view.
interface cdc_handshake_arbiter_if #(
  parameter int unsigned REQ_NUM  = 4,
  parameter int unsigned ID_WIDTH = 2
);
  logic [REQ_NUM-1:0]  req_pulse;
  logic [REQ_NUM-1:0]  req_pend;
  logic [REQ_NUM-1:0]  done_pulse;
  logic                xreq;
  logic [ID_WIDTH-1:0] xid;
  logic                xack_in;
  logic                busy;

  modport master (
    input  req_pulse,
    input  xack_in,
    output req_pend,
    output done_pulse,
    output xreq,
    output xid,
    output busy
  );

  modport slave (
    output req_pulse,
    output xack_in,
    input  req_pend,
    input  done_pulse,
    input  xreq,
    input  xid,
    input  busy
  );
endinterface

// File: rtl/cdc_handshake_arbiter.sv
// Round-robin sharing of one 4-phase req/ack CDC channel among REQ_NUM pulse requesters.
// The xid output is settled for a full cycle before xreq rises.
module cdc_handshake_arbiter #(
  parameter int unsigned REQ_NUM    = 4,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned SYNC_FLOPS = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  cdc_handshake_arbiter_if.master bus
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_REQ     = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]            r_state;
  logic [SYNC_FLOPS-1:0] r_sync;
  logic [REQ_NUM-1:0]    r_pend;
  logic [REQ_NUM-1:0]    r_done;
  logic                  r_xreq;
  logic [ID_WIDTH-1:0]   r_xid;
  logic [ID_WIDTH-1:0]   r_last;

  logic                  w_ack_s;
  logic                  w_found;
  logic [ID_WIDTH-1:0]   w_grant;
  logic [REQ_NUM-1:0]    w_gmask;
  logic [REQ_NUM-1:0]    w_clr;

  assign w_ack_s = r_sync[SYNC_FLOPS-1];
  assign w_gmask = {{(REQ_NUM-1){1'b0}}, 1'b1} << r_xid;
  assign w_clr   = (r_state == ST_DONE) ? w_gmask : '0;

  // First pending index after last_grant, wrapping modulo REQ_NUM.
  always_comb begin
    int unsigned        w_idx;
    logic [REQ_NUM-1:0] w_bits;
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = 0;
    w_bits  = '0;
    for (int unsigned k = 1; k <= REQ_NUM; k++) begin
      w_idx  = (32'(r_last) + k) % REQ_NUM;
      w_bits = r_pend >> w_idx;
      if (!w_found && w_bits[0]) begin
        w_found = 1'b1;
        w_grant = ID_WIDTH'(w_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sync  <= '0;
      r_pend  <= '0;
      r_done  <= '0;
      r_xreq  <= 1'b0;
      r_xid   <= '0;
      r_last  <= ID_WIDTH'(REQ_NUM - 1);
    end else begin
      r_sync <= {r_sync[SYNC_FLOPS-2:0], bus.xack_in};
      // A re-pulse in the DONE cycle survives the clear.
      r_pend <= (r_pend & ~w_clr) | bus.req_pulse;
      case (r_state)
        ST_IDLE: begin
          if (w_found && !w_ack_s) begin
            r_xid   <= w_grant;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_xreq  <= 1'b1;
          r_state <= ST_REQ;
        end
        ST_REQ: begin
          if (w_ack_s) begin
            r_xreq  <= 1'b0;
            r_state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!w_ack_s) begin
            r_done  <= w_gmask;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= '0;
          r_last  <= r_xid;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_pend   = r_pend;
  assign bus.done_pulse = r_done;
  assign bus.xreq       = r_xreq;
  assign bus.xid        = r_xid;
  assign bus.busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cdc_handshake_arbiter.sv
// Directed bench with a grant-order scoreboard and a far-side ack model.
module tb_cdc_handshake_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cdc_handshake_arbiter_if #(.REQ_NUM(N), .ID_WIDTH(IW)) bus ();

  cdc_handshake_arbiter #(.REQ_NUM(N), .ID_WIDTH(IW), .SYNC_FLOPS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int unsigned sb[$];

  logic auto_ack = 1'b1;
  logic xack_manual = 1'b0;
  logic far_d1 = 1'b0;
  logic far_d2 = 1'b0;
  logic prev_xreq = 1'b0;
  logic [IW-1:0] prev_xid = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Far side: ack follows xreq two cycles later.
  initial begin
    bus.xack_in = 1'b0;
    forever begin
      @(negedge clk);
      bus.xack_in = auto_ack ? far_d2 : xack_manual;
      far_d2 = far_d1;
      far_d1 = bus.xreq;
    end
  end

  // Monitor: grant ID at xreq rise, done pulses against the scoreboard, xid stability.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.xreq && !prev_xreq) begin
          check("xid_setup", {30'd0, prev_xid}, {30'd0, bus.xid});
          check("grant_order", {30'd0, bus.xid}, (sb.size() > 0) ? sb[0] : 32'hdead);
        end
        if (bus.xreq && prev_xreq) check("xid_stable", {30'd0, bus.xid}, {30'd0, prev_xid});
        if (bus.done_pulse != '0) begin
          done_cnt++;
          if (sb.size() == 0) check("done_unexpected", {28'd0, bus.done_pulse}, 32'd0);
          else check("done_onehot", {28'd0, bus.done_pulse}, 32'd1 << sb.pop_front());
        end
      end
      prev_xreq = bus.xreq;
      prev_xid  = bus.xid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    bus.req_pulse = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    sb.delete();
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    bus.req_pulse = m;
    @(negedge clk);
    bus.req_pulse = '0;
  endtask

  task automatic drain(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!bus.busy && bus.req_pend == '0 && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_xreq(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.xreq) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int base;
    bit ok;
    bus.req_pulse = '0;
    do_reset();

    // Reset state
    check("rst_pend", {28'd0, bus.req_pend}, 32'd0);
    check("rst_done", {28'd0, bus.done_pulse}, 32'd0);
    check("rst_xreq", {31'd0, bus.xreq}, 32'd0);
    check("rst_xid", {30'd0, bus.xid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);

    // 1: single request, latency
    base = done_cnt;
    sb.push_back(2);
    pulse(4'b0100);
    check("t1_pend", {28'd0, bus.req_pend}, 32'b0100);
    check("t1_busy0", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    check("t1_xid", {30'd0, bus.xid}, 32'd2);
    check("t1_xreq0", {31'd0, bus.xreq}, 32'd0);
    check("t1_busy1", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    check("t1_xreq1", {31'd0, bus.xreq}, 32'd1);
    drain("t1_drain");
    check("t1_done_cnt", done_cnt - base, 32'd1);
    check("t1_pend_clr", {28'd0, bus.req_pend}, 32'd0);

    // 2: all four at once after reset
    do_reset();
    base = done_cnt;
    for (int i = 0; i < 4; i++) sb.push_back(i);
    pulse(4'b1111);
    check("t2_pend", {28'd0, bus.req_pend}, 32'b1111);
    drain("t2_drain");
    check("t2_done_cnt", done_cnt - base, 32'd4);
    check("t2_busy", {31'd0, bus.busy}, 32'd0);

    // 3: round-robin wrap after serving 1
    do_reset();
    sb.push_back(1);
    pulse(4'b0010);
    drain("t3_drain1");
    sb.push_back(3);
    sb.push_back(0);
    pulse(4'b1001);
    drain("t3_drain2");

    // 4: merged re-pulse in REQ, then re-pulse in DONE
    do_reset();
    base = done_cnt;
    sb.push_back(1);
    pulse(4'b0010);
    wait_xreq("t4_xreq");
    pulse(4'b0010);
    drain("t4_drain1");
    check("t4_merged", done_cnt - base, 32'd1);
    base = done_cnt;
    sb.push_back(1);
    pulse(4'b0010);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done_pulse != '0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("t4_saw_done", {31'd0, ok}, 32'd1);
    sb.push_back(1);
    pulse(4'b0010);
    check("t4_pend_kept", {28'd0, bus.req_pend}, 32'b0010);
    drain("t4_drain2");
    check("t4_two_done", done_cnt - base, 32'd2);

    // 5: reset in REQ with ack held high
    do_reset();
    auto_ack = 1'b0;
    xack_manual = 1'b0;
    sb.push_back(1);
    pulse(4'b0010);
    wait_xreq("t5_xreq");
    xack_manual = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_xreq_drop", {31'd0, bus.xreq}, 32'd0);
    check("t5_pend_lost", {28'd0, bus.req_pend}, 32'd0);
    sb.delete();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    sb.push_back(2);
    pulse(4'b0100);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.xreq || bus.busy) ok = 1'b0;
      @(negedge clk);
    end
    check("t5_blocked", {31'd0, ok}, 32'd1);
    check("t5_pend_held", {28'd0, bus.req_pend}, 32'b0100);
    xack_manual = 1'b0;
    auto_ack = 1'b1;
    drain("t5_drain");

    // 6: ack never arrives
    do_reset();
    auto_ack = 1'b0;
    xack_manual = 1'b0;
    base = done_cnt;
    sb.push_back(0);
    pulse(4'b0001);
    wait_xreq("t6_xreq");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t6_xreq_held", {31'd0, bus.xreq}, 32'd1);
      check("t6_xid_held", {30'd0, bus.xid}, 32'd0);
    end
    check("t6_no_done", done_cnt - base, 32'd0);
    do_reset();
    auto_ack = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
